// File: rtl/lc3_pipe_pkg.sv
// Shared types and constants for the LC-3 pipeline bypass/forwarding logic.
// The entry at index k-1 of a stage array describes pipeline stage k.
package lc3_pipe_pkg;

  localparam int DEPTH       = 7;
  localparam int REGW        = 3;
  localparam int LOAD_READY  = 3;
  localparam int FLUSH_DEPTH = 2;

  typedef logic [REGW-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     is_load;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority matcher: one-hot select of the youngest in-flight producer,
// plus a stall request when that producer is a load whose data is not ready yet.
module fwd_match
  import lc3_pipe_pkg::*;
(
  input  fwd_entry_t [DEPTH-1:0] entries,
  input  reg_idx_t               src,
  input  logic                   used,
  output logic [DEPTH-1:0]       sel,
  output logic                   needs_stall
);

  logic found;

  always_comb begin
    sel         = '0;
    needs_stall = 1'b0;
    found       = 1'b0;
    // Lowest index is the youngest stage, so the first hit wins.
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && used && entries[k].valid && (entries[k].dest == src)) begin
        sel[k]      = 1'b1;
        needs_stall = entries[k].is_load && ((k + 1) < LOAD_READY);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_select_gen.sv
// Bypass scoreboard: shifts in-flight destination registers down the pipeline and
// drives the operand mux selects and the load-use stall for the decode stage.
module fwd_select_gen
  import lc3_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [REGW-1:0]  issue_dest,
  input  logic             issue_is_load,
  input  logic             flush,
  input  logic             src_a_used,
  input  logic [REGW-1:0]  src_a,
  input  logic             src_b_used,
  input  logic [REGW-1:0]  src_b,
  output logic [DEPTH-1:0] sel_a,
  output logic [DEPTH-1:0] sel_b,
  output logic             stall
);

  fwd_entry_t [DEPTH-1:0] stage_q;
  fwd_entry_t [DEPTH-1:0] stage_d;
  logic                   stall_a;
  logic                   stall_b;

  fwd_match u_match_a (
    .entries    (stage_q),
    .src        (src_a),
    .used       (src_a_used),
    .sel        (sel_a),
    .needs_stall(stall_a)
  );

  fwd_match u_match_b (
    .entries    (stage_q),
    .src        (src_b),
    .used       (src_b_used),
    .sel        (sel_b),
    .needs_stall(stall_b)
  );

  assign stall = stall_a | stall_b;

  always_comb begin
    stage_d = stage_q;
    if (advance) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        stage_d[k] = stage_q[k-1];
      end
      // A stalled or squashed decode instruction enters as a bubble.
      stage_d[0].valid   = issue_valid & issue_we & ~stall & ~flush;
      stage_d[0].dest    = issue_dest;
      stage_d[0].is_load = issue_is_load;
    end
    if (flush) begin
      for (int k = 0; k < FLUSH_DEPTH; k++) begin
        stage_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule
